// File: rtl/axi4s_upsizer.sv
// Packs RATIO narrow AXI4-Stream beats into one wide beat (slot 0 = first beat); tlast closes early.
// Latency: wide beat valid one cycle after the closing narrow beat is accepted.
// Backpressure: s_axis_tready drops only while a completed wide beat waits for m_axis_tready.
module axi4s_upsizer #(
  parameter int S_TDATA_WIDTH = 8,
  parameter int RATIO         = 4,
  parameter int TUSER_WIDTH   = 1,
  parameter int TDEST_WIDTH   = 1,
  parameter int TID_WIDTH     = 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [S_TDATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [S_TDATA_WIDTH/8-1:0]       s_axis_tkeep,
  input  logic [S_TDATA_WIDTH/8-1:0]       s_axis_tstrb,
  input  logic [TUSER_WIDTH-1:0]           s_axis_tuser,
  input  logic [TDEST_WIDTH-1:0]           s_axis_tdest,
  input  logic [TID_WIDTH-1:0]             s_axis_tid,
  input  logic                             s_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [S_TDATA_WIDTH*RATIO-1:0]   m_axis_tdata,
  output logic [S_TDATA_WIDTH/8*RATIO-1:0] m_axis_tkeep,
  output logic [S_TDATA_WIDTH/8*RATIO-1:0] m_axis_tstrb,
  output logic [TUSER_WIDTH*RATIO-1:0]     m_axis_tuser,
  output logic [TDEST_WIDTH-1:0]           m_axis_tdest,
  output logic [TID_WIDTH-1:0]             m_axis_tid,
  output logic                             m_axis_tlast,
  output logic                             id_err
);

  localparam int SW = S_TDATA_WIDTH;
  localparam int SK = S_TDATA_WIDTH / 8;
  localparam int MW = SW * RATIO;
  localparam int MK = SK * RATIO;
  localparam int UW = TUSER_WIDTH * RATIO;
  localparam int CW = $clog2(RATIO);

  logic [CW-1:0] cnt;
  logic          s_hs;
  logic          m_hs;
  logic          close_word;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign close_word    = (cnt == CW'(RATIO - 1)) || s_axis_tlast;

  // The accumulator is also the output register: while cnt != 0 no wide beat is pending.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tdest  <= '0;
      m_axis_tid    <= '0;
      m_axis_tlast  <= 1'b0;
      id_err        <= 1'b0;
    end else begin
      id_err <= 1'b0;
      if (m_hs) begin
        m_axis_tvalid <= 1'b0;
      end
      if (s_hs) begin
        if (cnt == '0) begin
          // Fresh word: slot 0 takes the beat, every other slot is cleared.
          m_axis_tdata <= MW'(s_axis_tdata);
          m_axis_tkeep <= MK'(s_axis_tkeep);
          m_axis_tstrb <= MK'(s_axis_tstrb);
          m_axis_tuser <= UW'(s_axis_tuser);
          m_axis_tdest <= s_axis_tdest;
          m_axis_tid   <= s_axis_tid;
        end else begin
          for (int k = 1; k < RATIO; k++) begin
            if (cnt == CW'(k)) begin
              m_axis_tdata[k*SW +: SW]                   <= s_axis_tdata;
              m_axis_tkeep[k*SK +: SK]                   <= s_axis_tkeep;
              m_axis_tstrb[k*SK +: SK]                   <= s_axis_tstrb;
              m_axis_tuser[k*TUSER_WIDTH +: TUSER_WIDTH] <= s_axis_tuser;
            end
          end
          id_err <= (s_axis_tdest != m_axis_tdest) || (s_axis_tid != m_axis_tid);
        end
        if (close_word) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= s_axis_tlast;
          cnt           <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4s_upsizer.sv
// Directed bench for axi4s_upsizer (8-bit narrow, RATIO 4, 2-bit tdest).
module tb_axi4s_upsizer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  s;
    logic [3:0]  u;
    logic [1:0]  dst;
    logic        l;
  } wbeat_t;

  logic        aclk;
  logic        aresetn;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  s_tdata;
  logic [0:0]  s_tkeep;
  logic [0:0]  s_tstrb;
  logic [0:0]  s_tuser;
  logic [1:0]  s_tdest;
  logic [0:0]  s_tid;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic [3:0]  m_tstrb;
  logic [3:0]  m_tuser;
  logic [1:0]  m_tdest;
  logic [0:0]  m_tid;
  logic        m_tlast;
  logic        id_err;

  int tests = 0;
  int fails = 0;
  int ierr_cnt = 0;
  wbeat_t wq[$];

  axi4s_upsizer #(
    .S_TDATA_WIDTH(8), .RATIO(4), .TUSER_WIDTH(1), .TDEST_WIDTH(2), .TID_WIDTH(1)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tdest(s_tdest), .s_axis_tid(s_tid), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tdest(m_tdest), .m_axis_tid(m_tid), .m_axis_tlast(m_tlast),
    .id_err(id_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Inputs change at posedge+1, so a handshake seen at negedge completes at the next posedge.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready)
      wq.push_back('{m_tdata, m_tkeep, m_tstrb, m_tuser, m_tdest, m_tlast});
    if (aresetn && id_err)
      ierr_cnt++;
  end

  task automatic drive(input logic [7:0] d, input logic k, input logic st, input logic u,
                       input logic [1:0] dst, input logic l);
    int w;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tstrb = st; s_tuser = u;
    s_tdest = dst; s_tid = 1'b0; s_tlast = l;
    w = 0;
    @(negedge aclk);
    while (!s_tready && w < 1000) begin
      @(negedge aclk);
      w++;
    end
    if (!s_tready) begin
      tests++; fails++;
      $display("FAIL drive_timeout: s_tready=%0b after %0d cycles, required 1", s_tready, w);
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int w;
    w = 0;
    while (wq.size() < n && w < 2000) begin
      @(posedge aclk); #1;
      w++;
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; m_tready = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tstrb = '0; s_tuser = '0; s_tdest = '0; s_tid = '0;
    #12;
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %0b want 0", m_tvalid); end
    tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL rst_tdata: got %h want 0", m_tdata); end
    tests++; if (m_tkeep !== 4'h0 || m_tstrb !== 4'h0 || m_tuser !== 4'h0) begin
      fails++; $display("FAIL rst_keep: keep %h strb %h user %h want 0", m_tkeep, m_tstrb, m_tuser); end
    tests++; if (m_tlast !== 1'b0 || m_tdest !== 2'd0 || id_err !== 1'b0) begin
      fails++; $display("FAIL rst_misc: last %0b dest %0d id_err %0b want 0", m_tlast, m_tdest, id_err); end
    tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL rst_sready: got %0b want 1", s_tready); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_full_word();
    wbeat_t b;
    wq.delete();
    drive(8'h11, 1, 1, 1, 0, 0);
    drive(8'h22, 1, 1, 0, 0, 0);
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL full_early_valid: got %0b want 0", m_tvalid); end
    drive(8'h33, 1, 1, 1, 0, 0);
    drive(8'h44, 1, 1, 1, 0, 1);
    tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL full_latency: tvalid %0b want 1", m_tvalid); end
    wait_beats(1);
    tests++;
    if (wq.size() != 1) begin fails++; $display("FAIL full_count: got %0d beats want 1", wq.size()); end
    else begin
      b = wq.pop_front();
      if (b.d !== 32'h44332211 || b.k !== 4'hF || b.s !== 4'hF || b.u !== 4'hD || b.l !== 1'b1) begin
        fails++;
        $display("FAIL full_beat: d %h k %h s %h u %h l %0b want 44332211 F F D 1", b.d, b.k, b.s, b.u, b.l);
      end
    end
  endtask

  task automatic test_partial();
    wbeat_t b;
    wq.delete();
    drive(8'hAA, 1, 1, 1, 0, 0);
    drive(8'hBB, 1, 1, 1, 0, 1);
    drive(8'h55, 1, 1, 0, 0, 1);
    wait_beats(2);
    tests++;
    if (wq.size() != 2) begin fails++; $display("FAIL part_count: got %0d beats want 2", wq.size()); end
    else begin
      b = wq.pop_front();
      if (b.d !== 32'h0000BBAA || b.k !== 4'h3 || b.s !== 4'h3 || b.u !== 4'h3 || b.l !== 1'b1) begin
        fails++;
        $display("FAIL part_beat: d %h k %h s %h u %h l %0b want 0000BBAA 3 3 3 1", b.d, b.k, b.s, b.u, b.l);
      end
      tests++;
      b = wq.pop_front();
      if (b.d !== 32'h00000055 || b.k !== 4'h1 || b.s !== 4'h1 || b.u !== 4'h0 || b.l !== 1'b1) begin
        fails++;
        $display("FAIL slot0_last: d %h k %h s %h u %h l %0b want 00000055 1 1 0 1", b.d, b.k, b.s, b.u, b.l);
      end
    end
  endtask

  task automatic test_null_beat();
    wbeat_t b;
    wq.delete();
    drive(8'hE1, 1, 1, 0, 0, 0);
    drive(8'hE2, 0, 0, 0, 0, 0);
    drive(8'hE3, 1, 1, 0, 0, 1);
    wait_beats(1);
    tests++;
    if (wq.size() != 1) begin fails++; $display("FAIL null_count: got %0d beats want 1", wq.size()); end
    else begin
      b = wq.pop_front();
      if (b.d !== 32'h00E3E2E1 || b.k !== 4'h5 || b.s !== 4'h5 || b.l !== 1'b1) begin
        fails++; $display("FAIL null_beat: d %h k %h s %h l %0b want 00E3E2E1 5 5 1", b.d, b.k, b.s, b.l);
      end
    end
  endtask

  task automatic test_back_to_back();
    wbeat_t b;
    wq.delete();
    m_tready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 8; i++) drive(8'(i), 1, 1, 0, 0, i == 8);
      end
      begin
        int w;
        int bad;
        w = 0; bad = 0;
        while (!m_tvalid && w < 100) begin
          @(negedge aclk);
          w++;
        end
        for (int c = 0; c < 10; c++) begin
          @(negedge aclk);
          if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 32'h04030201) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL hold_stable: %0d bad cycles want 0", bad); end
        tests++;
        if (wq.size() != 0) begin fails++; $display("FAIL hold_no_beat: got %0d beats want 0", wq.size()); end
        @(posedge aclk); #1;
        m_tready = 1'b1;
      end
    join
    wait_beats(2);
    tests++;
    if (wq.size() != 2) begin fails++; $display("FAIL b2b_count: got %0d beats want 2", wq.size()); end
    else begin
      b = wq.pop_front();
      if (b.d !== 32'h04030201 || b.k !== 4'hF || b.l !== 1'b0) begin
        fails++; $display("FAIL b2b_beat0: d %h k %h l %0b want 04030201 F 0", b.d, b.k, b.l);
      end
      tests++;
      b = wq.pop_front();
      if (b.d !== 32'h08070605 || b.k !== 4'hF || b.l !== 1'b1) begin
        fails++; $display("FAIL b2b_beat1: d %h k %h l %0b want 08070605 F 1", b.d, b.k, b.l);
      end
    end
  endtask

  task automatic test_id_err();
    wbeat_t b;
    int base;
    wq.delete();
    base = ierr_cnt;
    drive(8'hC1, 1, 1, 0, 2'd1, 0);
    drive(8'hC2, 1, 1, 0, 2'd1, 0);
    drive(8'hC3, 1, 1, 0, 2'd2, 0);
    drive(8'hC4, 1, 1, 0, 2'd1, 1);
    wait_beats(1);
    tests++;
    if (ierr_cnt - base != 1) begin fails++; $display("FAIL id_err_pulses: got %0d want 1", ierr_cnt - base); end
    tests++;
    if (wq.size() != 1) begin fails++; $display("FAIL id_count: got %0d beats want 1", wq.size()); end
    else begin
      b = wq.pop_front();
      if (b.d !== 32'hC4C3C2C1 || b.k !== 4'hF || b.dst !== 2'd1 || b.l !== 1'b1) begin
        fails++; $display("FAIL id_beat: d %h k %h dest %0d l %0b want C4C3C2C1 F 1 1", b.d, b.k, b.dst, b.l);
      end
    end
  endtask

  task automatic test_reset_mid();
    wbeat_t b;
    wq.delete();
    drive(8'hF1, 1, 1, 0, 0, 0);
    drive(8'hF2, 1, 1, 0, 0, 0);
    aresetn = 1'b0;
    #1;
    tests++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tkeep !== 4'h0) begin
      fails++; $display("FAIL mid_rst_state: valid %0b d %h k %h want 0 0 0", m_tvalid, m_tdata, m_tkeep);
    end
    #2;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    for (int i = 0; i < 4; i++) drive(8'hD1 + 8'(i), 1, 1, 0, 0, 0);
    wait_beats(1);
    repeat (4) @(posedge aclk);
    tests++;
    if (wq.size() != 1) begin fails++; $display("FAIL mid_rst_count: got %0d beats want 1", wq.size()); end
    else begin
      b = wq.pop_front();
      if (b.d !== 32'hD4D3D2D1 || b.k !== 4'hF || b.l !== 1'b0) begin
        fails++; $display("FAIL mid_rst_beat: d %h k %h l %0b want D4D3D2D1 F 0", b.d, b.k, b.l);
      end
    end
  endtask

  task automatic test_random();
    wbeat_t exp_q[$];
    wbeat_t b;
    wbeat_t e;
    logic   done;
    wq.delete();
    done = 1'b0;
    fork
      begin
        logic [31:0] ad;
        logic [3:0]  ak;
        logic [7:0]  bt;
        logic        last;
        int          m;
        int          len;
        ad = '0; ak = '0; m = 0;
        for (int p = 0; p < 1000; p++) begin
          len = $urandom_range(1, 17);
          for (int i = 0; i < len; i++) begin
            bt = 8'($urandom);
            last = (i == len - 1);
            if ($urandom_range(0, 1) == 1) begin
              @(posedge aclk); #1;
            end
            drive(bt, 1, 1, 0, 0, last);
            ad[m*8 +: 8] = bt;
            ak[m] = 1'b1;
            if (m == 3 || last) begin
              exp_q.push_back('{ad, ak, ak, 4'h0, 2'd0, last});
              ad = '0; ak = '0; m = 0;
            end else begin
              m++;
            end
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge aclk); #1;
          m_tready = ($urandom_range(0, 1) == 1);
        end
        m_tready = 1'b1;
      end
    join
    wait_beats(exp_q.size());
    tests++;
    if (wq.size() != exp_q.size()) begin
      fails++; $display("FAIL rand_count: got %0d beats want %0d", wq.size(), exp_q.size());
    end
    while (wq.size() > 0 && exp_q.size() > 0) begin
      b = wq.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (b.d !== e.d || b.k !== e.k || b.s !== e.s || b.l !== e.l) begin
        fails++;
        $display("FAIL rand_beat: d %h k %h l %0b want %h %h %0b", b.d, b.k, b.l, e.d, e.k, e.l);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_null_beat();
    test_back_to_back();
    test_id_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
